// File: rtl/tile_mux_pkg.sv
// Shared types and header-field layout for the tile local-port mux.
// Header beat layout: {.., channel id, source {Y,X}, destination {Y,X}}.
package tile_mux_pkg;

    typedef enum logic {
        EG_IDLE,
        EG_BUSY
    } egress_state_t;

    typedef enum logic [1:0] {
        IN_HDR,
        IN_BODY,
        IN_DROP
    } ingress_state_t;

    // Width of one {Y,X} coordinate pair
    function automatic int xy_w(input int xy_sz);
        return 2 * xy_sz;
    endfunction

    // Destination {Y,X} sits at the bottom of the header
    function automatic int dst_lsb(input int xy_sz);
        return 0 * xy_sz;
    endfunction

    // Source {Y,X} follows the destination
    function automatic int src_lsb(input int xy_sz);
        return 2 * xy_sz;
    endfunction

    // Channel id follows the source
    function automatic int ch_lsb(input int xy_sz);
        return 4 * xy_sz;
    endfunction

endpackage

// File: rtl/tile_rr_arbiter.sv
// Combinational round-robin pick: first requester strictly after last_grant,
// wrapping around to channel 0.
module tile_rr_arbiter #(
    parameter int NCH  = 4,
    parameter int CH_W = $clog2(NCH)
) (
    input  logic [NCH-1:0]  req,
    input  logic [CH_W-1:0] last_grant,
    output logic            gnt_vld,
    output logic [NCH-1:0]  gnt_oh,
    output logic [CH_W-1:0] gnt_idx
);

    logic found;

    // Pass 1 looks above last_grant, pass 2 wraps to the lowest requester
    always_comb begin
        gnt_vld = |req;
        gnt_oh  = '0;
        gnt_idx = '0;
        found   = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (!found && req[i] && (i > int'(last_grant))) begin
                found     = 1'b1;
                gnt_oh[i] = 1'b1;
                gnt_idx   = CH_W'(i);
            end
        end
        for (int i = 0; i < NCH; i++) begin
            if (!found && req[i]) begin
                found     = 1'b1;
                gnt_oh[i] = 1'b1;
                gnt_idx   = CH_W'(i);
            end
        end
    end

endmodule

// File: rtl/tile_local_port_mux.sv
// Tile local-port mux: NCH accelerator AXI-Stream channels share the switch
// local-in port (packet round-robin, header src/channel stamping), and switch
// local-out packets are steered back to the channel named in their header.
// Optional: define TILE_MUX_DROP_CNT_EN to count dropped ingress packets;
// otherwise drop_cnt reads 0 and no counter exists.
module tile_local_port_mux
    import tile_mux_pkg::*;
#(
    parameter int BW         = 32,
    parameter int BWB        = BW / 8,
    parameter int NCH        = 4,
    parameter int CH_W       = $clog2(NCH),
    parameter int XY_SZ      = 3,
    parameter int DROP_CNT_W = 16
) (
    input  logic                  clk_line,
    input  logic                  clk_line_rst_high,
    input  logic [2*XY_SZ-1:0]    HsrcId,
    // egress from accelerators
    input  logic [NCH-1:0]        acc_in_TVALID,
    output logic [NCH-1:0]        acc_in_TREADY,
    input  logic [NCH-1:0]        acc_in_TLAST,
    input  logic [NCH*BW-1:0]     acc_in_TDATA,
    input  logic [NCH*BWB-1:0]    acc_in_TKEEP,
    // to switch local-in
    output logic                  noc_out_TVALID,
    input  logic                  noc_out_TREADY,
    output logic                  noc_out_TLAST,
    output logic [BW-1:0]         noc_out_TDATA,
    output logic [BWB-1:0]        noc_out_TKEEP,
    // from switch local-out
    input  logic                  noc_in_TVALID,
    output logic                  noc_in_TREADY,
    input  logic                  noc_in_TLAST,
    input  logic [BW-1:0]         noc_in_TDATA,
    input  logic [BWB-1:0]        noc_in_TKEEP,
    // ingress to accelerators
    output logic [NCH-1:0]        acc_out_TVALID,
    input  logic [NCH-1:0]        acc_out_TREADY,
    output logic [NCH-1:0]        acc_out_TLAST,
    output logic [NCH*BW-1:0]     acc_out_TDATA,
    output logic [NCH*BWB-1:0]    acc_out_TKEEP,
    output logic [DROP_CNT_W-1:0] drop_cnt
);

    localparam int SRC_LSB = src_lsb(XY_SZ);
    localparam int CH_LSB  = ch_lsb(XY_SZ);
    localparam int XYW     = xy_w(XY_SZ);

    // ------------------------------------------------------------------
    // Egress: accelerators -> switch
    // ------------------------------------------------------------------
    logic [NCH-1:0][BW-1:0]  in_data;
    logic [NCH-1:0][BWB-1:0] in_keep;

    egress_state_t   eg_state, eg_next;
    logic [CH_W-1:0] grant_q;
    logic [NCH-1:0]  grant_oh_q;
    logic [CH_W-1:0] last_grant;
    logic            first_beat;
    logic            eg_hs;

    logic            arb_vld;
    logic [NCH-1:0]  arb_oh;
    logic [CH_W-1:0] arb_idx;

    assign in_data = acc_in_TDATA;
    assign in_keep = acc_in_TKEEP;
    assign eg_hs   = noc_out_TVALID & noc_out_TREADY;

    tile_rr_arbiter #(
        .NCH  (NCH),
        .CH_W (CH_W)
    ) u_arb (
        .req        (acc_in_TVALID),
        .last_grant (last_grant),
        .gnt_vld    (arb_vld),
        .gnt_oh     (arb_oh),
        .gnt_idx    (arb_idx)
    );

    // Egress state, grant register and round-robin pointer
    always_ff @(posedge clk_line) begin
        if (clk_line_rst_high) begin
            eg_state   <= EG_IDLE;
            grant_q    <= '0;
            grant_oh_q <= '0;
            last_grant <= CH_W'(NCH - 1);
            first_beat <= 1'b1;
        end else begin
            eg_state <= eg_next;
            if (eg_state == EG_IDLE) begin
                if (arb_vld) begin
                    grant_q    <= arb_idx;
                    grant_oh_q <= arb_oh;
                end
                first_beat <= 1'b1;
            end else if (eg_hs) begin
                first_beat <= 1'b0;
                if (noc_out_TLAST)
                    last_grant <= grant_q;
            end
        end
    end

    // Egress next state and the combinational forward path with header stamping
    always_comb begin
        eg_next        = eg_state;
        noc_out_TVALID = 1'b0;
        noc_out_TLAST  = acc_in_TLAST[grant_q];
        noc_out_TKEEP  = in_keep[grant_q];
        noc_out_TDATA  = in_data[grant_q];
        acc_in_TREADY  = '0;
        if (first_beat) begin
            noc_out_TDATA[SRC_LSB +: XYW] = HsrcId;
            noc_out_TDATA[CH_LSB +: CH_W] = grant_q;
        end
        case (eg_state)
            EG_IDLE: begin
                // grant is registered here, which costs one bubble per packet
                if (arb_vld)
                    eg_next = EG_BUSY;
            end
            EG_BUSY: begin
                noc_out_TVALID = acc_in_TVALID[grant_q];
                acc_in_TREADY  = grant_oh_q & {NCH{noc_out_TREADY}};
                if (acc_in_TVALID[grant_q] && noc_out_TREADY && acc_in_TLAST[grant_q])
                    eg_next = EG_IDLE;
            end
            default: eg_next = EG_IDLE;
        endcase
        // hold every handshake low while reset is applied
        if (clk_line_rst_high) begin
            noc_out_TVALID = 1'b0;
            acc_in_TREADY  = '0;
            eg_next        = EG_IDLE;
        end
    end

    // ------------------------------------------------------------------
    // Ingress: switch -> accelerators
    // ------------------------------------------------------------------
    ingress_state_t  in_state, in_next;
    logic [CH_W-1:0] in_ch_q;
    logic [CH_W-1:0] hdr_ch;
    logic            hdr_ok;
    logic [CH_W-1:0] in_sel;
    logic            in_route;

    assign hdr_ch = noc_in_TDATA[CH_LSB +: CH_W];
    assign hdr_ok = (int'(hdr_ch) < NCH);

    // data/keep/last are broadcast; only the selected TVALID qualifies them
    assign acc_out_TDATA = {NCH{noc_in_TDATA}};
    assign acc_out_TKEEP = {NCH{noc_in_TKEEP}};
    assign acc_out_TLAST = {NCH{noc_in_TLAST}};

    // Ingress state and locked channel
    always_ff @(posedge clk_line) begin
        if (clk_line_rst_high) begin
            in_state <= IN_HDR;
            in_ch_q  <= '0;
        end else begin
            in_state <= in_next;
            if (in_state == IN_HDR)
                in_ch_q <= hdr_ch;
        end
    end

    // Ingress routing / discard decisions
    always_comb begin
        in_next        = in_state;
        in_sel         = in_ch_q;
        in_route       = 1'b0;
        noc_in_TREADY  = 1'b0;
        acc_out_TVALID = '0;
        case (in_state)
            IN_HDR: begin
                if (hdr_ok) begin
                    in_sel   = hdr_ch;
                    in_route = 1'b1;
                    if (noc_in_TVALID && acc_out_TREADY[hdr_ch] && !noc_in_TLAST)
                        in_next = IN_BODY;
                end else begin
                    noc_in_TREADY = 1'b1;
                    if (noc_in_TVALID && !noc_in_TLAST)
                        in_next = IN_DROP;
                end
            end
            IN_BODY: begin
                in_route = 1'b1;
                if (noc_in_TVALID && acc_out_TREADY[in_ch_q] && noc_in_TLAST)
                    in_next = IN_HDR;
            end
            IN_DROP: begin
                noc_in_TREADY = 1'b1;
                if (noc_in_TVALID && noc_in_TLAST)
                    in_next = IN_HDR;
            end
            default: in_next = IN_HDR;
        endcase
        if (in_route) begin
            acc_out_TVALID[in_sel] = noc_in_TVALID;
            noc_in_TREADY          = acc_out_TREADY[in_sel];
        end
        if (clk_line_rst_high) begin
            noc_in_TREADY  = 1'b0;
            acc_out_TVALID = '0;
            in_next        = IN_HDR;
        end
    end

`ifdef TILE_MUX_DROP_CNT_EN
    logic                  drop_hs;
    logic [DROP_CNT_W-1:0] drop_q;

    // a dropped packet is counted once, on its header handshake
    assign drop_hs = !clk_line_rst_high && (in_state == IN_HDR) && !hdr_ok && noc_in_TVALID;

    // Saturating dropped-packet counter
    always_ff @(posedge clk_line) begin
        if (clk_line_rst_high)
            drop_q <= '0;
        else if (drop_hs && !(&drop_q))
            drop_q <= drop_q + 1'b1;
    end

    assign drop_cnt = drop_q;
`else
    assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_tile_local_port_mux.sv
// Directed bench for tile_local_port_mux: a 4-channel instance for most
// scenarios and a 3-channel instance for invalid-channel drops.
module tb_tile_local_port_mux;

    localparam int BW  = 32;
    localparam int BWB = BW / 8;
    localparam int NCH = 4;
    localparam int N3  = 3;
    localparam int DW  = 16;

    logic clk_line = 1'b0;
    logic rst      = 1'b0;
    logic [5:0] hsrc = '0;

    logic [NCH-1:0]     ai_v, ai_r, ai_l;
    logic [NCH*BW-1:0]  ai_d;
    logic [NCH*BWB-1:0] ai_k;
    logic               no_v, no_r, no_l;
    logic [BW-1:0]      no_d;
    logic [BWB-1:0]     no_k;
    logic               ni_v, ni_r, ni_l;
    logic [BW-1:0]      ni_d;
    logic [BWB-1:0]     ni_k;
    logic [NCH-1:0]     ao_v, ao_r, ao_l;
    logic [NCH*BW-1:0]  ao_d;
    logic [NCH*BWB-1:0] ao_k;
    logic [DW-1:0]      drop;

    logic [N3-1:0]      ai3_v = '0, ai3_l = '0, ai3_r;
    logic [N3*BW-1:0]   ai3_d = '0;
    logic [N3*BWB-1:0]  ai3_k = '0;
    logic               no3_v, no3_l, no3_r = 1'b0;
    logic [BW-1:0]      no3_d;
    logic [BWB-1:0]     no3_k;
    logic               ni3_r;
    logic [N3-1:0]      ao3_v, ao3_r, ao3_l;
    logic [N3*BW-1:0]   ao3_d;
    logic [N3*BWB-1:0]  ao3_k;
    logic [DW-1:0]      drop3;

    int pass_cnt  = 0;
    int total_cnt = 0;

`ifdef TILE_MUX_DROP_CNT_EN
    localparam logic [DW-1:0] EXP_DROP = 16'd1;
`else
    localparam logic [DW-1:0] EXP_DROP = 16'd0;
`endif

    always #5 clk_line = ~clk_line;

    tile_local_port_mux #(.BW(BW), .NCH(NCH), .XY_SZ(3), .DROP_CNT_W(DW)) dut (
        .clk_line(clk_line), .clk_line_rst_high(rst), .HsrcId(hsrc),
        .acc_in_TVALID(ai_v), .acc_in_TREADY(ai_r), .acc_in_TLAST(ai_l),
        .acc_in_TDATA(ai_d), .acc_in_TKEEP(ai_k),
        .noc_out_TVALID(no_v), .noc_out_TREADY(no_r), .noc_out_TLAST(no_l),
        .noc_out_TDATA(no_d), .noc_out_TKEEP(no_k),
        .noc_in_TVALID(ni_v), .noc_in_TREADY(ni_r), .noc_in_TLAST(ni_l),
        .noc_in_TDATA(ni_d), .noc_in_TKEEP(ni_k),
        .acc_out_TVALID(ao_v), .acc_out_TREADY(ao_r), .acc_out_TLAST(ao_l),
        .acc_out_TDATA(ao_d), .acc_out_TKEEP(ao_k),
        .drop_cnt(drop)
    );

    tile_local_port_mux #(.BW(BW), .NCH(N3), .XY_SZ(3), .DROP_CNT_W(DW)) dut3 (
        .clk_line(clk_line), .clk_line_rst_high(rst), .HsrcId(hsrc),
        .acc_in_TVALID(ai3_v), .acc_in_TREADY(ai3_r), .acc_in_TLAST(ai3_l),
        .acc_in_TDATA(ai3_d), .acc_in_TKEEP(ai3_k),
        .noc_out_TVALID(no3_v), .noc_out_TREADY(no3_r), .noc_out_TLAST(no3_l),
        .noc_out_TDATA(no3_d), .noc_out_TKEEP(no3_k),
        .noc_in_TVALID(ni_v), .noc_in_TREADY(ni3_r), .noc_in_TLAST(ni_l),
        .noc_in_TDATA(ni_d), .noc_in_TKEEP(ni_k),
        .acc_out_TVALID(ao3_v), .acc_out_TREADY(ao3_r), .acc_out_TLAST(ao3_l),
        .acc_out_TDATA(ao3_d), .acc_out_TKEEP(ao3_k),
        .drop_cnt(drop3)
    );

    task automatic idle_inputs();
        ai_v  = '0; ai_l = '0; ai_d = '0; ai_k = '1;
        no_r  = 1'b1;
        ni_v  = 1'b0; ni_l = 1'b0; ni_d = '0; ni_k = '1;
        ao_r  = '1;
        ao3_r = '1;
    endtask

    // leaves the caller at a falling edge with reset just released
    task automatic do_reset();
        @(negedge clk_line);
        rst = 1'b1;
        idle_inputs();
        repeat (3) @(negedge clk_line);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk_line);
        rst  = 1'b1;
        hsrc = 6'b000_001;
        ai_v = '1; ai_l = '0; ai_k = '1; no_r = 1'b1;
        ni_v = 1'b1; ni_d = '0; ni_l = 1'b0; ni_k = '1; ao_r = '1; ao3_r = '1;
        for (int c = 0; c < NCH; c++) ai_d[c*BW +: BW] = 32'h0000_3000 | 32'(c);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk_line); #1;
            total_cnt++;
            if ({no_v, ai_r, ni_r, ao_v} !== '0)
                $display("FAIL reset_hs got no_v=%b ai_r=%b ni_r=%b ao_v=%b want all 0", no_v, ai_r, ni_r, ao_v);
            else pass_cnt++;
            total_cnt++;
            if ({ni3_r, ao3_v, no3_v, ai3_r} !== '0)
                $display("FAIL reset_hs3 got ni_r=%b ao_v=%b no_v=%b ai_r=%b want all 0", ni3_r, ao3_v, no3_v, ai3_r);
            else pass_cnt++;
            total_cnt++;
            if (drop !== '0 || drop3 !== '0)
                $display("FAIL reset_drop got %0d/%0d want 0", drop, drop3);
            else pass_cnt++;
        end
        @(negedge clk_line);
        rst  = 1'b0;
        ni_v = 1'b0;
        #1;
        total_cnt++;
        if (no_v !== 1'b0 || ai_r !== 4'b0000)
            $display("FAIL reset_bubble got no_v=%b ai_r=%b want 0 0000", no_v, ai_r);
        else pass_cnt++;
        @(negedge clk_line); #1;
        total_cnt++;
        if (no_v !== 1'b1 || ai_r !== 4'b0001)
            $display("FAIL reset_first_grant got no_v=%b ai_r=%b want 1 0001", no_v, ai_r);
        else pass_cnt++;
        total_cnt++;
        if (no_d[13:12] !== 2'd0)
            $display("FAIL reset_first_ch got %0d want 0", no_d[13:12]);
        else pass_cnt++;
    endtask

    // every channel streams 3-beat packets back to back
    task automatic test_fairness();
        int bc [NCH];
        int exp_ch, exp_b;
        logic exp_v;
        logic [31:0] exp_d;
        hsrc = 6'b101_110;
        do_reset();
        for (int c = 0; c < NCH; c++) bc[c] = 0;
        for (int n = 0; n < 16; n++) begin
            for (int c = 0; c < NCH; c++) begin
                ai_v[c] = 1'b1;
                ai_d[c*BW +: BW] = (bc[c] == 0) ? (32'hA500_0FC0 | 32'(c))
                                                : (32'hB000_0000 | (32'(c) << 8) | 32'(bc[c]));
                ai_l[c] = (bc[c] == 2);
            end
            #1;
            exp_ch = (n / 4) % 4;
            exp_b  = (n % 4) - 1;
            exp_v  = (n % 4) != 0;
            total_cnt++;
            if (no_v !== exp_v || ai_r !== (exp_v ? (4'b0001 << exp_ch) : 4'b0000))
                $display("FAIL fair_grant cyc%0d got v=%b rdy=%b want v=%b ch=%0d", n, no_v, ai_r, exp_v, exp_ch);
            else pass_cnt++;
            if (exp_v) begin
                exp_d = (exp_b == 0) ? (32'hA500_0B80 | (32'(exp_ch) << 12) | 32'(exp_ch))
                                     : (32'hB000_0000 | (32'(exp_ch) << 8) | 32'(exp_b));
                total_cnt++;
                if (no_d !== exp_d || no_l !== (exp_b == 2))
                    $display("FAIL fair_data cyc%0d got %h/%b want %h/%b", n, no_d, no_l, exp_d, (exp_b == 2));
                else pass_cnt++;
            end
            for (int c = 0; c < NCH; c++)
                if (ai_v[c] && ai_r[c]) bc[c] = (bc[c] + 1) % 3;
            @(negedge clk_line);
        end
    endtask

    // channel 2 header stamping, a mid-packet stall, then handover to channel 0
    task automatic test_stamping();
        logic        v2 [7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [31:0] d2 [7] = '{32'hAB, 32'hAB, 32'h0, 32'h1234_5678, 32'hFFFF_FFFF, 32'h0, 32'h0};
        logic        l2 [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic        v0 [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        logic        ev [7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        logic [31:0] ed [7] = '{32'h0, 32'h0000_24EB, 32'h0, 32'h1234_5678, 32'hFFFF_FFFF, 32'h0, 32'h0000_04C0};
        logic        el [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [3:0]  er [7] = '{4'b0000, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0001};
        hsrc = 6'b010_011;
        do_reset();
        for (int n = 0; n < 7; n++) begin
            ai_v = {1'b0, v2[n], 1'b0, v0[n]};
            ai_l = {1'b0, l2[n], 2'b00};
            ai_d = '0;
            ai_d[2*BW +: BW] = d2[n];
            #1;
            total_cnt++;
            if (no_v !== ev[n] || ai_r !== er[n])
                $display("FAIL stamp_hs cyc%0d got v=%b rdy=%b want v=%b rdy=%b", n, no_v, ai_r, ev[n], er[n]);
            else pass_cnt++;
            if (ev[n]) begin
                total_cnt++;
                if (no_d !== ed[n] || no_l !== el[n])
                    $display("FAIL stamp_data cyc%0d got %h/%b want %h/%b", n, no_d, no_l, ed[n], el[n]);
                else pass_cnt++;
            end
            @(negedge clk_line);
        end
    endtask

    // channel-1 packet with a toggling consumer
    task automatic test_ingress_route();
        logic [31:0] beats [4] = '{32'h0000_1005, 32'h0000_00D1, 32'h0000_00D2, 32'h0000_00D3};
        logic        rdy   [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        int          eb    [6] = '{0, 1, 1, 2, 3, 3};
        int bi = 0;
        do_reset();
        for (int n = 0; n < 7; n++) begin
            ni_v = (bi < 4);
            ni_d = beats[bi % 4];
            ni_l = (bi == 3);
            ao_r = {2'b11, (n < 6) ? rdy[n] : 1'b1, 1'b1};
            #1;
            if (n < 6) begin
                total_cnt++;
                if (ao_v !== 4'b0010 || ni_r !== rdy[n])
                    $display("FAIL route_hs cyc%0d got ao_v=%b ni_r=%b want 0010 %b", n, ao_v, ni_r, rdy[n]);
                else pass_cnt++;
                total_cnt++;
                if (ao_d[1*BW +: BW] !== beats[eb[n]] || ao_l[1] !== (eb[n] == 3))
                    $display("FAIL route_data cyc%0d got %h/%b want %h/%b", n, ao_d[1*BW +: BW], ao_l[1], beats[eb[n]], (eb[n] == 3));
                else pass_cnt++;
            end else begin
                total_cnt++;
                if (ao_v !== 4'b0000)
                    $display("FAIL route_idle got ao_v=%b want 0000", ao_v);
                else pass_cnt++;
            end
            if (ni_v && ni_r) bi++;
            @(negedge clk_line);
        end
    endtask

    // 3-channel instance: channel 3 does not exist and the packet is discarded
    task automatic test_drop();
        int k = 0;
        do_reset();
        for (int n = 0; n < 5; n++) begin
            ni_v = 1'b1;
            ni_d = (k == 0) ? 32'h0000_3000 : (32'hDEAD_0000 | 32'(k));
            ni_l = (k == 4);
            #1;
            total_cnt++;
            if (ni3_r !== 1'b1 || ao3_v !== 3'b000)
                $display("FAIL drop_beat cyc%0d got ni_r=%b ao_v=%b want 1 000", n, ni3_r, ao3_v);
            else pass_cnt++;
            if (ni_v && ni3_r) k++;
            @(negedge clk_line);
        end
        ni_v = 1'b1; ni_d = 32'h0000_2007; ni_l = 1'b0;
        #1;
        total_cnt++;
        if (ao3_v !== 3'b100 || ao3_d[2*BW +: BW] !== 32'h0000_2007 || ni3_r !== 1'b1)
            $display("FAIL drop_next_hdr got ao_v=%b d=%h ni_r=%b want 100 00002007 1", ao3_v, ao3_d[2*BW +: BW], ni3_r);
        else pass_cnt++;
        @(negedge clk_line);
        ni_d = 32'h0000_0099; ni_l = 1'b1;
        #1;
        total_cnt++;
        if (ao3_v !== 3'b100 || ao3_d[2*BW +: BW] !== 32'h0000_0099 || ao3_l[2] !== 1'b1)
            $display("FAIL drop_next_body got ao_v=%b d=%h l=%b want 100 00000099 1", ao3_v, ao3_d[2*BW +: BW], ao3_l[2]);
        else pass_cnt++;
        @(negedge clk_line);
        ni_v = 1'b0; ni_l = 1'b0;
        #1;
        total_cnt++;
        if (drop3 !== EXP_DROP)
            $display("FAIL drop_cnt got %0d want %0d", drop3, EXP_DROP);
        else pass_cnt++;
    endtask

    // egress channel 3 and ingress channel 2 in flight together
    task automatic test_concurrency();
        logic [31:0] eb    [4] = '{32'h0000_0001, 32'h0000_00E1, 32'h0000_00E2, 32'h0000_00E3};
        logic [31:0] exp_e [4] = '{32'h0000_3281, 32'h0000_00E1, 32'h0000_00E2, 32'h0000_00E3};
        logic [31:0] ib    [4] = '{32'h0000_2004, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
        int ei = 0;
        int ii = 0;
        hsrc = 6'b001_010;
        do_reset();
        for (int n = 0; n < 5; n++) begin
            ai_v = (ei < 4) ? 4'b1000 : 4'b0000;
            ai_d[3*BW +: BW] = eb[ei % 4];
            ai_l[3] = (ei == 3);
            ni_v = (ii < 4);
            ni_d = ib[ii % 4];
            ni_l = (ii == 3);
            #1;
            total_cnt++;
            if (n == 0) begin
                if (no_v !== 1'b0)
                    $display("FAIL conc_eg cyc%0d got v=%b want 0", n, no_v);
                else pass_cnt++;
            end else begin
                if (no_v !== 1'b1 || no_d !== exp_e[n-1] || no_l !== (n == 4))
                    $display("FAIL conc_eg cyc%0d got %b/%h/%b want 1/%h/%b", n, no_v, no_d, no_l, exp_e[n-1], (n == 4));
                else pass_cnt++;
            end
            total_cnt++;
            if (n < 4) begin
                if (ao_v !== 4'b0100 || ao_d[2*BW +: BW] !== ib[n] || ni_r !== 1'b1)
                    $display("FAIL conc_in cyc%0d got %b/%h/%b want 0100/%h/1", n, ao_v, ao_d[2*BW +: BW], ni_r, ib[n]);
                else pass_cnt++;
            end else begin
                if (ao_v !== 4'b0000)
                    $display("FAIL conc_in cyc%0d got %b want 0000", n, ao_v);
                else pass_cnt++;
            end
            if (no_v && no_r) ei++;
            if (ni_v && ni_r) ii++;
            @(negedge clk_line);
        end
    endtask

    // reset lands mid-packet on both paths; the leftover beats become new packets
    task automatic test_abort();
        logic [31:0] ab    [4] = '{32'h0000_0005, 32'h0000_0FC7, 32'h0000_00A2, 32'h0000_00A3};
        logic [31:0] bb    [4] = '{32'h0000_0000, 32'h0000_0011, 32'h0000_3055, 32'h0000_0077};
        logic        e_nov [7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [31:0] e_nod [7] = '{32'h0, 32'h0000_1285, 32'h0, 32'h0, 32'h0000_1287, 32'h0000_00A2, 32'h0000_00A3};
        logic [3:0]  e_aov [7] = '{4'b0001, 4'b0001, 4'b0000, 4'b1000, 4'b1000, 4'b0000, 4'b0000};
        int          e_ach [7] = '{0, 0, 0, 3, 3, 0, 0};
        logic [31:0] e_aod [7] = '{32'h0, 32'h0000_0011, 32'h0, 32'h0000_3055, 32'h0000_0077, 32'h0, 32'h0};
        int ei = 0;
        int ii = 0;
        hsrc = 6'b001_010;
        do_reset();
        for (int n = 0; n < 7; n++) begin
            rst  = (n == 2);
            ai_v = (ei < 4) ? 4'b0010 : 4'b0000;
            ai_d[1*BW +: BW] = ab[ei % 4];
            ai_l[1] = (ei == 3);
            ni_v = (ii < 4);
            ni_d = bb[ii % 4];
            ni_l = (ii == 3);
            #1;
            total_cnt++;
            if (no_v !== e_nov[n] || (e_nov[n] && (no_d !== e_nod[n] || no_l !== (n == 6))))
                $display("FAIL abort_eg cyc%0d got %b/%h/%b want %b/%h/%b", n, no_v, no_d, no_l, e_nov[n], e_nod[n], (n == 6));
            else pass_cnt++;
            total_cnt++;
            if (ao_v !== e_aov[n] || (e_aov[n] != 4'b0000 && ao_d[e_ach[n]*BW +: BW] !== e_aod[n]))
                $display("FAIL abort_in cyc%0d got %b/%h want %b/%h", n, ao_v, ao_d[e_ach[n]*BW +: BW], e_aov[n], e_aod[n]);
            else pass_cnt++;
            if (n == 2) begin
                total_cnt++;
                if (ai_r !== 4'b0000 || ni_r !== 1'b0)
                    $display("FAIL abort_rst_rdy got ai_r=%b ni_r=%b want 0000 0", ai_r, ni_r);
                else pass_cnt++;
            end
            if (n == 4) begin
                total_cnt++;
                if (ai_r !== 4'b0010)
                    $display("FAIL abort_regrant got ai_r=%b want 0010", ai_r);
                else pass_cnt++;
            end
            if (no_v && no_r) ei++;
            if (ni_v && ni_r) ii++;
            @(negedge clk_line);
        end
        rst = 1'b0;
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_fairness();
        test_stamping();
        test_ingress_route();
        test_drop();
        test_concurrency();
        test_abort();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got no finish want finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/tile_local_port_mux.md
Name: tile_local_port_mux

Overview:
- Parametrised successor of the single-accelerator local-port hookup in a tile.
- Multiplexes NCH accelerator AXI-Stream channels onto the one switch local-in port, and demultiplexes switch local-out packets back to NCH channels.
- Arbitration is round-robin at packet granularity. Each egress header has its source-tile and channel fields stamped.
- Sits between tile_noc local ports and NCH accelerator instances, all on clk_line.

Parameters:
- BW, 32, stream data width (bits)
- BWB, BW/8, TKEEP width
- NCH, 4, number of accelerator channels (2..16)
- CH_W, $clog2(NCH), channel-id field width
- XY_SZ, 3, tile coordinate width per axis
- DROP_CNT_W, 16, drop counter width

Ports:
- clk_line  in  1  line clock
- clk_line_rst_high  in  1  synchronous active-high reset
- HsrcId  in  2*XY_SZ  this tile {Y,X}
- acc_in_TVALID/TREADY/TLAST  in/out/in  NCH  egress from accelerators
- acc_in_TDATA  in  NCH*BW  egress data, channel i at [i*BW+:BW]
- acc_in_TKEEP  in  NCH*BWB  egress keep
- noc_out_TVALID/TREADY/TLAST  out/in/out  1  to switch local-in
- noc_out_TDATA/TKEEP  out  BW/BWB  to switch local-in
- noc_in_TVALID/TREADY/TLAST  in/out/in  1  from switch local-out
- noc_in_TDATA/TKEEP  in  BW/BWB  from switch local-out
- acc_out_TVALID/TREADY/TLAST  out/in/out  NCH  ingress to accelerators
- acc_out_TDATA/TKEEP  out  NCH*BW/NCH*BWB  ingress data/keep
- drop_cnt  out  DROP_CNT_W  dropped ingress packet count

Behaviour:
- Header beat = first beat of a packet:
  - [2*XY_SZ-1:0] destination {Y,X}
  - [4*XY_SZ-1:2*XY_SZ] source {Y,X}
  - [4*XY_SZ+CH_W-1:4*XY_SZ] channel id
- Reset (synchronous, all outputs):
  - noc_out_TVALID=0, acc_out_TVALID=0, all TREADY=0, drop_cnt=0.
  - Egress FSM=EG_IDLE, ingress FSM=IN_HDR.
  - RR pointer last_grant=NCH-1, so the first grant goes to channel 0.
- Reset mid-packet: the partial packet is abandoned with no completion beat. Upstream remainder is handled as new packets afterwards.
- Egress FSM:
  - EG_IDLE: if any acc_in_TVALID, register grant = first valid channel after last_grant (wrapping) and go to EG_BUSY. This costs 1 bubble cycle per packet. No TREADY asserted in EG_IDLE.
  - EG_BUSY: forward the granted channel combinationally. noc_out_* = acc_in_*[g]; acc_in_TREADY[g] = noc_out_TREADY; other TREADY=0.
  - Header stamping: on the first beat, overwrite the source field with HsrcId and the channel field with g. Other bits pass unchanged. A first_beat flag clears on the first handshake.
  - On the TLAST handshake: last_grant<=g, go to EG_IDLE.
  - TVALID dropping mid-packet only stalls; the grant is held.
- Ingress FSM:
  - IN_HDR: decode ch = channel field of noc_in_TDATA combinationally.
  - If ch<NCH: route the beat to acc_out[ch]; noc_in_TREADY = acc_out_TREADY[ch]. On handshake without TLAST go to IN_BODY(ch); with TLAST stay in IN_HDR.
  - If ch>=NCH: noc_in_TREADY=1; on handshake drop_cnt++ (saturating at all-ones). Go to IN_DROP unless TLAST.
  - IN_BODY: locked to ch; forward beats; on TLAST handshake go to IN_HDR.
  - IN_DROP: TREADY=1, discard beats; on TLAST go to IN_HDR.
- Non-selected acc_out_TVALID=0. Data/keep may be broadcast but are qualified only by TVALID.
- Egress and ingress are fully independent and may be active in the same cycle.
- Zero-latency (combinational) data paths; no buffering. Sustained throughput is 1 beat/cycle within a packet.

Optional Feature:
- TILE_MUX_DROP_CNT_EN:
  - Defined: drop_cnt implemented as above.
  - Undefined: drop_cnt tied to 0, no counter flops. Invalid-channel packets are still consumed and discarded.

Decomposition:
- Package tile_mux_pkg holds:
  - header field offset/width functions (DST_LSB, SRC_LSB, CH_LSB in terms of XY_SZ)
  - egress_state_t {EG_IDLE, EG_BUSY}
  - ingress_state_t {IN_HDR, IN_BODY, IN_DROP}
- One sub-module: tile_rr_arbiter (NCH requests, last_grant in, one-hot/encoded grant out; combinational).

Test Plan:
- Reset: assert clk_line_rst_high for 3 cycles with all inputs valid -> all TVALID/TREADY=0, drop_cnt=0. The first egress grant after release is channel 0.
- Fairness: NCH=4, all channels continuously send 3-beat packets -> noc_out packet order 0,1,2,3,0,... Exactly 1 idle cycle between packets.
- Stamping: HsrcId=6'b010_011, channel 2 sends header 0x0000_00AB -> noc_out first beat has src field=6'b010_011 and ch field=2, low 6 bits=0x2B. Body beats are unmodified.
- Ingress routing: noc_in header with ch=1, 4 beats, acc_out_TREADY[1] toggling 1,0,1,1,0,1 -> all 4 beats appear only on acc_out[1] in order. No other acc_out_TVALID goes high.
- Drop: NCH=3, ingress packet with ch=3 of 5 beats -> noc_in_TREADY=1 for 5 cycles, no acc_out_TVALID, drop_cnt=1 (0 with TILE_MUX_DROP_CNT_EN undefined). The next valid packet routes normally.
- Concurrency/abort: egress and ingress packets run simultaneously at full rate with no interference. Reset asserted mid-packet (beat 2 of 4) -> FSMs return to EG_IDLE/IN_HDR, and the next input beat is treated as a header.
